mdu_unit: RTL
=============

# mdu_unit

Multiply/divide unit sitting in the E stage beside the ALU. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle, holds the HI/LO registers, and serves MFHI/MFLO reads. It also raises a stall request that the D-stage hazard controller ORs into its existing stall, so that any MDU instruction in D waits while the unit is busy.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; must be ≥1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low. Reset is asserted while `reset`=0.
- `op_valid` input 1: an E-stage MDU instruction is present this cycle; it is not a bubble.
- `mdu_op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `rs_data` input 32: forwarded rs operand (E stage).
- `rt_data` input 32: forwarded rt operand (E stage).
- `d_md_use` input 1: the D-stage instruction is any MDU op (0–7).
- `start` output 1: combinational; asserted when `op_valid` and `mdu_op`≤3 and `busy`=0.
- `busy` output 1: registered; a multi-cycle operation is in progress.
- `hi`, `lo` output 32 each: architectural HI/LO registers.
- `mf_data` output 32: combinational. Equals `hi` when `mdu_op`=6, `lo` when `mdu_op`=7, and 0 otherwise.
- `md_stall` output 1: combinational, equal to `d_md_use & (busy | start)`.

## Operation
- The state is a two-state FSM, IDLE and RUN, implemented as `busy` plus a down-counter `cnt` of width clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Reset values: `busy`=0, `cnt`=0, `hi`=0, `lo`=0, and the internal result registers are 0.
- IDLE→RUN happens on an edge with `start`=1. At that edge:
  - compute and latch the 64-bit result into `res_hi`/`res_lo`;
  - set `cnt` to MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3);
  - set `busy` to 1.
- In RUN, `cnt` decrements every edge. On the edge where `cnt`=1, `hi`←`res_hi`, `lo`←`res_lo`, `busy`←0, and the FSM returns to IDLE.
- MULT computes signed 32×32→64 and MULTU computes unsigned 32×32→64. The upper 32 bits go to HI and the lower 32 bits to LO.
- DIV is signed: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU is unsigned.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (rt=0) still occupies DIV_CYCLES, but `hi`/`lo` are left unchanged at completion.
- MTHI/MTLO, when `op_valid` and `busy`=0, write `rs_data` into `hi`/`lo` at the next edge. No busy cycles are added.
- MFHI/MFLO have no state effect. `mf_data` reflects `hi`/`lo` as they stand in the current cycle.
- If `op_valid` is asserted for ops 0–5 while `busy`=1, the unit ignores it; `hi`, `lo` and `cnt` are untouched. The upstream `md_stall` guarantees this never happens legally, and the bench flags it with an assertion.
- Reset asserted mid-RUN immediately clears `busy`, `cnt`, `hi` and `lo`. The pending result is discarded.

## Timing
- Operation accepted at edge t, with `start` high in cycle t−1 (when the op is presented). `busy` is high from cycle t through cycle t+N−1, where N is the op's cycle count. `hi`/`lo` update at edge t+N. A D-stage MFHI therefore stalls through cycle t+N−1 and reads the new value in E at t+N or later.
- `md_stall` covers the accept cycle through `start`, so the instruction right behind a MULT stalls with zero slack.
- A new `start` is legal in the cycle where `busy` has just dropped, giving back-to-back operations with no idle gap.
- `start` and `mdu_op` are sampled only at the accept edge. `rs_data`/`rt_data` may change freely afterwards.

## Test plan
- Reset, then idle: `hi`=`lo`=0, `busy`=0, `md_stall`=0, with `d_md_use`=1.
- MULT rs=0xFFFFFFFE, rt=3 → `busy` high exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x2, `lo`=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/0 with prior `hi`=`lo`=0x5 → `busy` high 10 cycles, then `hi`=`lo`=0x5.
- MTHI 0x1234 then MFHI the next cycle → `mf_data`=0x1234. MULT with `d_md_use`=1 held → `md_stall` high from the `start` cycle through the last busy cycle, and low the cycle after.
- MULT started, then `reset` driven to 0 on the 3rd busy cycle → `busy`, `hi` and `lo` all become 0 asynchronously. After release, a new DIV 100/7 gives `lo`=14, `hi`=2.

Source files
------------

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : E-stage multiply/divide unit. Runs MULT/MULTU/DIV/DIVU over a
//            fixed number of busy cycles, executes MTHI/MTLO in one cycle,
//            holds HI/LO, serves MFHI/MFLO and raises the D-stage stall.
// Revision : 1.0  initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_md_use,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic        md_stall
);

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [2:0] c_OP_MTHI = 3'd4;
    localparam logic [2:0] c_OP_MTLO = 3'd5;
    localparam logic [2:0] c_OP_MFHI = 3'd6;
    localparam logic [2:0] c_OP_MFLO = 3'd7;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    logic               r_div_zero;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_start;
    logic               w_done;
    logic               w_idle;
    logic [63:0]        w_mul_a;
    logic [63:0]        w_mul_b;
    logic [63:0]        w_prod;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [31:0]        w_abs_rs;
    logic [31:0]        w_abs_rt;
    logic [31:0]        w_den;
    logic [31:0]        w_quo_mag;
    logic [31:0]        w_rem_mag;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;

    assign w_idle  = (r_state == c_IDLE);
    assign w_start = op_valid && !mdu_op[2] && w_idle;
    assign w_done  = (r_state == c_RUN) && (r_cnt == c_CNT_ONE);

    // Result datapath: one 64-bit multiplier (sign-extended for MULT) and a
    // magnitude divider whose signs are restored afterwards for DIV.
    always_comb begin
        w_mul_a   = {(mdu_op[0] ? 32'd0 : {32{rs_data[31]}}), rs_data};
        w_mul_b   = {(mdu_op[0] ? 32'd0 : {32{rt_data[31]}}), rt_data};
        w_prod    = w_mul_a * w_mul_b;
        w_rs_neg  = !mdu_op[0] && rs_data[31];
        w_rt_neg  = !mdu_op[0] && rt_data[31];
        w_abs_rs  = w_rs_neg ? -rs_data : rs_data;
        w_abs_rt  = w_rt_neg ? -rt_data : rt_data;
        // Divisor of zero is replaced so the divider never sees x/0; the
        // result is discarded at completion anyway.
        w_den     = (rt_data == 32'd0) ? 32'd1 : w_abs_rt;
        w_quo_mag = w_abs_rs / w_den;
        w_rem_mag = w_abs_rs % w_den;
        w_quo     = (w_rs_neg ^ w_rt_neg) ? -w_quo_mag : w_quo_mag;
        w_rem     = w_rs_neg ? -w_rem_mag : w_rem_mag;
    end

    // State register: IDLE/RUN, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: enter RUN on accept, leave on the final count.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_state_next = c_RUN;
            c_RUN:   if (w_done)  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Counter and pending result: latched at accept, counted down in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_res_hi   <= 32'd0;
            r_res_lo   <= 32'd0;
            r_div_zero <= 1'b0;
        end else if (w_start) begin
            if (mdu_op[1]) begin
                r_res_hi <= w_rem;
                r_res_lo <= w_quo;
                r_cnt    <= c_DIV_LOAD;
            end else begin
                r_res_hi <= w_prod[63:32];
                r_res_lo <= w_prod[31:0];
                r_cnt    <= c_MULT_LOAD;
            end
            r_div_zero <= mdu_op[1] && (rt_data == 32'd0);
        end else if (r_state == c_RUN) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // HI/LO: committed on completion (unless divide by zero) or by MTHI/MTLO
    // while idle. Completion only happens in RUN, so the two never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            if (!r_div_zero) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end else if (op_valid && w_idle) begin
            if (mdu_op == c_OP_MTHI) r_hi <= rs_data;
            if (mdu_op == c_OP_MTLO) r_lo <= rs_data;
        end
    end

    // Outputs: handshake, register reads and the D-stage stall request.
    always_comb begin
        start    = w_start;
        busy     = (r_state == c_RUN);
        hi       = r_hi;
        lo       = r_lo;
        md_stall = d_md_use && ((r_state == c_RUN) || w_start);
        case (mdu_op)
            c_OP_MFHI: mf_data = r_hi;
            c_OP_MFLO: mf_data = r_lo;
            default:   mf_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire
